// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
//   Shared definitions for the FIFO burst read controller.
//   - state_t / ST_* : FSM encoding for the burst controller (2 bits).
//   - SKID_DEPTH     : number of entries in the output skid buffer. It also
//                      caps how many words may be popped but not yet handed
//                      to the stream consumer.
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
//   Two-entry, first-in first-out valid/ready buffer. The head entry drives
//   out_data/out_valid directly from flops, so the outputs stay stable while
//   out_valid is high and out_ready is low.
//
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     in_valid   : write strobe; the producer only writes when there is room
//                  (occ < 2, or occ == 2 with a same-cycle read)
//     in_data    : write data
//     out_valid  : head entry holds a word
//     out_ready  : consumer accepts the head word
//     out_data   : head word
//     occ        : number of stored words, 0..2
// ---------------------------------------------------------------------------
module skid_buf2
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    localparam logic [1:0] OCC_FULL = 2'(SKID_DEPTH);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             wr;
    logic             rd;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign occ       = occ_q;

    assign rd = out_valid & out_ready;
    // A write into a full buffer is only honoured when the head leaves in
    // the same cycle; otherwise it would overwrite an unread word.
    assign wr = in_valid & ((occ_q != OCC_FULL) | rd);

    // Next-state for the two entries. The head is always entry 0; a read
    // shifts the tail forward so the output mux stays trivial.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (wr) begin
                    head_d = in_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (wr && rd) begin
                    head_d = in_data;
                end else if (rd) begin
                    occ_d = 2'd0;
                end else if (wr) begin
                    tail_d = in_data;
                    occ_d  = 2'd2;
                end
            end
            default: begin
                if (rd) begin
                    head_d = tail_q;
                    if (wr) begin
                        tail_d = in_data;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//   Read-side controller for the synchronous push/pop FIFO. A burst command
//   (word count) is accepted in IDLE; the controller then pops the FIFO while
//   it is not empty and there is room downstream, captures the registered
//   FIFO output one cycle after each pop, and streams the words out on a
//   valid/ready interface with the final word flagged by m_last.
//
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     cmd_valid  : burst request
//     cmd_ready  : high in IDLE only
//     cmd_len    : words to read (0 completes immediately with a done pulse)
//     fifo_empty : FIFO empty flag
//     fifo_pop   : pop strobe to the FIFO (combinational)
//     fifo_dout  : FIFO read data, valid the cycle after a pop
//     m_valid    : stream data valid
//     m_ready    : stream consumer ready
//     m_data     : stream data
//     m_last     : final word of the burst, qualified by m_valid
//     done       : one-cycle pulse after the last word is accepted
//     busy       : high while a burst is in progress (RUN or DRAIN)
// ---------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             done,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] pop_rem_q, pop_rem_d;
    logic [LEN_W-1:0] out_rem_q, out_rem_d;
    logic             inflight_q, inflight_d;
    logic             done_q, done_d;

    logic [1:0]       skid_occ;
    logic [1:0]       occ_left;
    logic [2:0]       pending;
    logic             room;
    logic             out_fire;

    // Output buffer: the word captured from the FIFO lands here the cycle
    // after its pop, and the stream is driven from its head entry.
    skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   (fifo_dout),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .occ       (skid_occ)
    );

    assign out_fire = m_valid & m_ready;

    // Downstream room check. A word leaving the buffer this cycle frees its
    // slot before a word popped now could arrive (two cycles from now at the
    // earliest it needs a slot, one cycle for the word already in flight),
    // so the outgoing handshake is credited. This keeps one word per cycle
    // with the consumer always ready while never holding more than two
    // words between the pop and the stream handshake.
    assign occ_left = skid_occ - {1'b0, out_fire};
    assign pending  = {1'b0, occ_left} + {2'b00, inflight_q};
    assign room     = (pending < 3'(SKID_DEPTH));

    assign fifo_pop = (state_q == ST_RUN) & ~fifo_empty & (pop_rem_q != '0) & room;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign done      = done_q;

    // out_rem counts words not yet accepted, and the head is always the next
    // word to be accepted, so the head is the last word when one remains.
    assign m_last = m_valid & (out_rem_q == LEN_W'(1));

    // Burst FSM and counters. Both counters only count down and are guarded
    // against wrapping below zero.
    always_comb begin
        state_d    = state_q;
        pop_rem_d  = pop_rem_q;
        out_rem_d  = out_rem_q;
        inflight_d = fifo_pop;
        done_d     = 1'b0;

        if (out_fire && (out_rem_q != '0)) begin
            out_rem_d = out_rem_q - LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d   = ST_RUN;
                        pop_rem_d = cmd_len;
                        out_rem_d = cmd_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (fifo_pop) begin
                    pop_rem_d = pop_rem_q - LEN_W'(1);
                    if (pop_rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_fire && (out_rem_q == LEN_W'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers. Reset drops any word still in flight from the
    // FIFO by clearing inflight, so it is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pop_rem_q  <= '0;
            out_rem_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pop_rem_q  <= pop_rem_d;
            out_rem_q  <= out_rem_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader. A small queue models the
//   synchronous FIFO (registered dout, updated on the clock edge of a pop).
//   Inputs are driven 1 time unit after the rising edge; a monitor records
//   stream handshakes, pops and done pulses on the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       done;
    logic       busy;

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc = 0;

    logic [7:0] fq[$];
    logic [7:0] out_data[$];
    logic       out_last[$];
    int         out_cyc[$];
    int         pop_count;
    int         done_count;
    int         done_cyc;
    int         pop_empty_viol;
    int         outstanding_viol;
    int         pops_total = 0;
    int         acc_total = 0;

    fifo_burst_reader #(
        .WIDTH (8),
        .LEN_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a pop presents the front word on dout after the edge.
    always @(posedge clk) begin
        logic [7:0] w;
        if (fifo_pop && (fq.size() > 0)) begin
            w = fq.pop_front();
            fifo_dout <= w;
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: pops issued minus words accepted equals words held between
    // the FIFO and the stream; it must never exceed two.
    always @(negedge clk) begin
        if (rst) begin
            pops_total = 0;
            acc_total  = 0;
        end else begin
            if ((pops_total - acc_total) > 2) outstanding_viol++;
            if (fifo_pop && fifo_empty) pop_empty_viol++;
            if (fifo_pop) begin
                pops_total++;
                pop_count++;
            end
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_last.push_back(m_last);
                out_cyc.push_back(cyc);
                acc_total++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatch++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        fq.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
        pop_count        = 0;
        done_count       = 0;
        done_cyc         = -1;
        pop_empty_viol   = 0;
        outstanding_viol = 0;
    endtask

    // Presents a command for one cycle; k returns the cycle count at which
    // it was driven (accepted on the following edge).
    task automatic applyStimulus(input logic [7:0] len, output int k);
        cmd_valid = 1'b1;
        cmd_len   = len;
        k         = cyc;
        step();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [31:0] last_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < out_last.size() && i < 32; i++) m[i] = out_last[i];
        return m;
    endfunction

    initial begin
        int k;
        int n;
        int fed;
        int order_err;
        int last_cnt;
        int last_idx;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = 8'd0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        clear_logs();
        repeat (3) step();

        // Reset values
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_fifo_pop", fifo_pop, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Test 1: four preloaded words, consumer always ready
        $display("[TB] test 1: burst of 4, m_ready=1");
        clear_logs();
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        m_ready = 1'b1;
        checkOutput("t1_cmd_ready", cmd_ready, 1);
        applyStimulus(8'd4, k);
        repeat (12) step();
        checkOutput("t1_count", out_data.size(), 4);
        checkOutput("t1_w0", out_data[0], 8'h11);
        checkOutput("t1_w1", out_data[1], 8'h12);
        checkOutput("t1_w2", out_data[2], 8'h13);
        checkOutput("t1_w3", out_data[3], 8'h14);
        checkOutput("t1_first_cycle", out_cyc[0], k + 3);
        checkOutput("t1_last_cycle", out_cyc[3], k + 6);
        checkOutput("t1_last_mask", last_mask(), 32'b1000);
        checkOutput("t1_pops", pop_count, 4);
        checkOutput("t1_done_count", done_count, 1);
        checkOutput("t1_done_cycle", done_cyc, k + 7);
        checkOutput("t1_idle_ready", cmd_ready, 1);
        checkOutput("t1_idle_busy", busy, 0);

        // Test 2: backpressure for 10 cycles with 5 words available
        $display("[TB] test 2: burst of 3 under backpressure");
        clear_logs();
        for (int i = 0; i < 5; i++) push_word(8'h21 + 8'(i));
        m_ready = 1'b0;
        applyStimulus(8'd3, k);
        checkOutput("t2_cmd_ready_busy", cmd_ready, 0);
        repeat (9) step();
        checkOutput("t2_stall_pops", pop_count, 2);
        checkOutput("t2_stall_valid", m_valid, 1);
        checkOutput("t2_stall_data", m_data, 8'h21);
        checkOutput("t2_stall_last", m_last, 0);
        checkOutput("t2_stall_count", out_data.size(), 0);
        m_ready = 1'b1;
        repeat (10) step();
        checkOutput("t2_count", out_data.size(), 3);
        checkOutput("t2_w0", out_data[0], 8'h21);
        checkOutput("t2_w1", out_data[1], 8'h22);
        checkOutput("t2_w2", out_data[2], 8'h23);
        checkOutput("t2_last_mask", last_mask(), 32'b100);
        checkOutput("t2_pops", pop_count, 3);
        checkOutput("t2_fifo_left", fq.size(), 2);
        checkOutput("t2_done_count", done_count, 1);
        checkOutput("t2_outstanding", outstanding_viol, 0);

        // Test 3: FIFO runs dry mid-burst (holds 0x24,0x25), refilled later
        $display("[TB] test 3: FIFO empties mid-burst");
        clear_logs();
        m_ready = 1'b1;
        applyStimulus(8'd4, k);
        repeat (5) step();
        checkOutput("t3_dry_pops", pop_count, 2);
        checkOutput("t3_dry_valid", m_valid, 0);
        checkOutput("t3_dry_busy", busy, 1);
        push_word(8'h33);
        push_word(8'h34);
        repeat (12) step();
        checkOutput("t3_count", out_data.size(), 4);
        checkOutput("t3_w0", out_data[0], 8'h24);
        checkOutput("t3_w1", out_data[1], 8'h25);
        checkOutput("t3_w2", out_data[2], 8'h33);
        checkOutput("t3_w3", out_data[3], 8'h34);
        checkOutput("t3_last_mask", last_mask(), 32'b1000);
        checkOutput("t3_pops", pop_count, 4);
        checkOutput("t3_pop_empty", pop_empty_viol, 0);
        checkOutput("t3_done_count", done_count, 1);

        // Test 4: zero-length burst
        $display("[TB] test 4: zero-length burst");
        clear_logs();
        applyStimulus(8'd0, k);
        checkOutput("t4_done_pulse", done, 1);
        checkOutput("t4_cmd_ready", cmd_ready, 1);
        checkOutput("t4_busy", busy, 0);
        step();
        checkOutput("t4_done_clear", done, 0);
        repeat (5) step();
        checkOutput("t4_pops", pop_count, 0);
        checkOutput("t4_count", out_data.size(), 0);
        checkOutput("t4_done_count", done_count, 1);

        // Test 5: reset after two of six words are delivered
        $display("[TB] test 5: reset mid-burst");
        clear_logs();
        for (int i = 0; i < 6; i++) push_word(8'h51 + 8'(i));
        m_ready = 1'b1;
        applyStimulus(8'd6, k);
        repeat (4) step();
        checkOutput("t5_pre_count", out_data.size(), 2);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", m_valid, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_ready", cmd_ready, 1);
        checkOutput("t5_rst_pop", fifo_pop, 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        checkOutput("t5_no_done", done_count, 0);
        checkOutput("t5_fifo_left", fq.size(), 2);
        clear_logs();
        applyStimulus(8'd1, k);
        repeat (6) step();
        checkOutput("t5_new_count", out_data.size(), 1);
        checkOutput("t5_new_word", out_data[0], 8'h55);
        checkOutput("t5_new_last", last_mask(), 32'b1);
        checkOutput("t5_new_pops", pop_count, 1);
        checkOutput("t5_new_done", done_count, 1);

        // Test 6: 255-word burst, random consumer, 16-deep FIFO kept fed
        $display("[TB] test 6: long burst with random m_ready");
        fq.delete();
        fifo_empty = 1'b1;
        clear_logs();
        fed = 0;
        while (fq.size() < 16) begin
            push_word(8'(fed + 1));
            fed++;
        end
        applyStimulus(8'd255, k);
        n = 0;
        while ((out_data.size() < 255) && (n < 4000)) begin
            if ((fq.size() < 16) && (fed < 255)) begin
                push_word(8'(fed + 1));
                fed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1'b1;
        repeat (4) step();
        order_err = 0;
        last_cnt  = 0;
        last_idx  = -1;
        for (int i = 0; i < out_data.size(); i++) begin
            if (out_data[i] !== 8'(i + 1)) order_err++;
            if (out_last[i]) begin
                last_cnt++;
                last_idx = i;
            end
        end
        checkOutput("t6_count", out_data.size(), 255);
        checkOutput("t6_order_errors", order_err, 0);
        checkOutput("t6_last_count", last_cnt, 1);
        checkOutput("t6_last_index", last_idx, 254);
        checkOutput("t6_pops", pop_count, 255);
        checkOutput("t6_outstanding", outstanding_viol, 0);
        checkOutput("t6_pop_empty", pop_empty_viol, 0);
        checkOutput("t6_done_count", done_count, 1);
        checkOutput("t6_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
